// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operation/result handshake bundle for alu_multicycle
interface alu_multicycle_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             illegal;

  modport master (
    output in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, illegal
  );

  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute unit: single-cycle arith/logic/compare, one-bit-per-cycle shifts
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        reset,
  alu_multicycle_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;

  localparam logic [1:0] SK_SRA = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SLL = 2'd2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_val;
  logic             alu_ill;
  logic             is_shift;
  logic [1:0]       kind_in;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;

  assign shamt = bus.SrcB[SHW-1:0];

  // Single-cycle datapath; shift codes are handled by the iterative path instead.
  always_comb begin
    alu_val  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    kind_in  = SK_SRA;
    case (bus.ALUControl)
      OP_ADD:  alu_val = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_val = bus.SrcA - bus.SrcB;
      OP_AND:  alu_val = bus.SrcA & bus.SrcB;
      OP_OR:   alu_val = bus.SrcA | bus.SrcB;
      OP_XOR:  alu_val = bus.SrcA ^ bus.SrcB;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_SRA: begin
        is_shift = 1'b1;
        kind_in  = SK_SRA;
      end
      OP_SRL: begin
        is_shift = 1'b1;
        kind_in  = SK_SRL;
      end
      OP_SLL: begin
        is_shift = 1'b1;
        kind_in  = SK_SLL;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (kind_q)
      SK_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      SK_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
      default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (!is_shift) begin
            result_d  = alu_val;
            zero_d    = (alu_val == '0);
            illegal_d = alu_ill;
            state_d   = S_DONE;
          end else if (shamt == '0) begin
            result_d  = bus.SrcA;
            zero_d    = (bus.SrcA == '0);
            illegal_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            work_d  = bus.SrcA;
            cnt_d   = shamt;
            kind_d  = kind_in;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        // The final shift lands straight in the result register, saving a cycle.
        if (cnt_q == SHW'(1)) begin
          result_d  = shifted;
          zero_d    = (shifted == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      kind_q    <= SK_SRA;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle
module tb_alu_multicycle;

  logic clk;
  logic reset;
  int   cycle;
  int   tests;
  int   failed;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, output logic ill);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return $unsigned($signed(a) >>> sh);
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a >> sh;
      4'd7: return a << sh;
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return a ^ b;
      default: begin
        ill = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'd4 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // rmode: 0 = out_ready high, 1 = random, 2 = held low
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int rmode);
    exp_t e;
    bit   ok;
    int   n;
    ok = 0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      bus.out_ready = (rmode == 1) ? ($urandom_range(3) != 0) : (rmode == 0);
      if (bus.in_ready && !reset) begin
        bus.in_valid   = 1'b1;
        bus.ALUControl = c;
        bus.SrcA       = a;
        bus.SrcB       = b;
        e.res = ref_res(c, a, b, e.ill);
        e.lat = ref_lat(c, b);
        e.acc = cycle + 1;
        sb.push_back(e);
        ok = 1;
      end
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.ALUControl = 4'($urandom);
    bus.SrcA       = $urandom;
    bus.SrcB       = $urandom;
    bus.out_ready  = (rmode == 1) ? ($urandom_range(3) != 0) : (rmode == 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor samples mid-low-phase, after the driver's negedge updates.
  bit          seen;
  int          first_cyc;
  logic [31:0] held_res;
  logic        held_z;
  logic        held_i;
  bit          stable_ok;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      seen = 0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen      = 1;
        first_cyc = cycle;
        held_res  = bus.ALUResult;
        held_z    = bus.Zero;
        held_i    = bus.illegal;
        stable_ok = 1;
      end else if (bus.ALUResult !== held_res || bus.Zero !== held_z || bus.illegal !== held_i) begin
        stable_ok = 0;
      end
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", bus.ALUResult, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("result", bus.ALUResult, e.res);
          chk("zero", 32'(bus.Zero), 32'(e.res == 32'd0));
          chk("illegal", 32'(bus.illegal), 32'(e.ill));
          chk("latency", 32'(first_cyc - e.acc + 1), 32'(e.lat));
          chk("held_stable", 32'(stable_ok), 32'd1);
          chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        end
        seen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.in_valid   = 1'b0;
    bus.ALUControl = 4'd0;
    bus.SrcA       = 32'd0;
    bus.SrcB       = 32'd0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.ALUResult, 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd1);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);

    do_op(4'b0000, 32'd5, 32'd7, 0);
    do_op(4'b0001, 32'd3, 32'd5, 0);
    do_op(4'b0001, 32'd9, 32'd9, 0);
    do_op(4'b0111, 32'h1, 32'd4, 0);
    do_op(4'b0100, 32'h80000000, 32'd31, 0);
    do_op(4'b0110, 32'h80000000, 32'd31, 0);
    do_op(4'b0110, 32'hDEADBEEF, 32'h20, 0);
    do_op(4'b0101, 32'hFFFFFFFF, 32'd1, 0);
    do_op(4'b1000, 32'hFFFFFFFF, 32'd1, 0);
    do_op(4'b1010, 32'h1234, 32'h5678, 0);
    do_op(4'b0000, 32'h1, 32'h1, 0);
    drain();

    // Backpressure with a blocked second request.
    do_op(4'b1001, 32'hF0F0, 32'h0FF0, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.ALUControl = 4'b0000;
      bus.SrcA       = 32'd1;
      bus.SrcB       = 32'd2;
      #2;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", bus.ALUResult, 32'h0000FF00);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    // Reset in the middle of a long shift.
    do_op(4'b0111, 32'h3, 32'd20, 0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", bus.ALUResult, 32'd0);
    chk("mid_rst_zero", 32'(bus.Zero), 32'd1);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    quiet = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) quiet = 0;
    end
    chk("mid_rst_no_result", 32'(quiet), 32'd1);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'($urandom_range(15));
      a = $urandom;
      b = $urandom;
      if (($urandom_range(3) == 0) && c != 4'd4 && c != 4'd6 && c != 4'd7) b = a;
      do_op(c, a, b, 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle execute unit that consumes the 4-bit `ALUControl` encoding produced by the ALU decoder and returns `ALUResult` and `Zero` over a valid/ready handshake. Arithmetic, logic and compare operations complete in one cycle. Shifts are iterative, one bit position per cycle, so no barrel shifter is needed. The block sits in the execute stage of the multi-cycle core, between the decode/control path and the result writeback mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width, a power of two, at least 2.
- `SHW`, default $clog2(WIDTH): shift-amount width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: an operation is presented.
- `in_ready`, out, 1: the block can accept an operation.
- `ALUControl`, in, 4: operation code, sampled on accept.
- `SrcA`, in, WIDTH: operand A, sampled on accept.
- `SrcB`, in, WIDTH: operand B, sampled on accept. Shifts use `SrcB[SHW-1:0]` as the shift amount.
- `out_valid`, out, 1: the result is valid.
- `out_ready`, in, 1: the consumer takes the result.
- `ALUResult`, out, WIDTH: registered result.
- `Zero`, out, 1: `ALUResult == 0`.
- `illegal`, out, 1: the current result came from an undefined code. Valid with `out_valid`.

## Operation
- Opcodes:
  - 0000 add.
  - 0001 sub.
  - 0010 and.
  - 0011 or.
  - 0100 sra.
  - 0101 slt (signed).
  - 0110 srl.
  - 0111 sll.
  - 1000 sltu (unsigned).
  - 1001 xor.
  - 1010–1111: undefined. Result 0, `illegal`=1.
- Arithmetic: add and sub wrap modulo 2^WIDTH. No carry or overflow output. slt and sltu return 0 or 1, zero-extended to WIDTH.
- States:
  - IDLE: `in_ready`=1.
    - `in_valid` with a non-shift code: compute and register the result, go to DONE.
    - `in_valid` with a shift code and shamt=0: register `SrcA` unchanged, go to DONE.
    - `in_valid` with a shift code and shamt>0: load the working register with `SrcA`, load the counter with shamt, go to SHIFT.
  - SHIFT: each cycle, shift the working register one position and decrement the counter.
    - sll: fill with 0.
    - srl: fill with 0.
    - sra: fill with the MSB of the working register.
    - When the counter reaches 1, this last shift writes `ALUResult` and the state goes to DONE.
  - DONE: `out_valid`=1 and outputs are held stable. When `out_ready`=1, go to IDLE.
- `in_ready`=0 in SHIFT and DONE. `in_valid` in those states is ignored and not queued.
- Operands are captured only on accept. Input changes after accept have no effect.
- `Zero` and `illegal` are registered together with `ALUResult`.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `ALUResult`=0, `Zero`=1, `illegal`=0, counter 0.

## Timing
- Accept happens on the rising edge where `in_ready && in_valid`.
- Non-shift ops and shamt=0: `out_valid` rises 1 cycle after accept.
- Shift with shamt=N (N>0): `out_valid` rises N+1 cycles after accept. The worst case, N=WIDTH-1, is WIDTH cycles.
- Result hand-off: happens on the edge where `out_valid && out_ready`. `in_ready` returns to 1 the next cycle.
  - There is no same-cycle turnaround: at least one IDLE cycle separates consecutive operations.
  - The block therefore has at most one operation in flight.
- `out_ready` held low: the result and flags are held indefinitely, with no loss.
- `out_ready` high before `out_valid` has no effect.
- Reset asserted in any state, including mid-SHIFT or in DONE:
  - The in-flight operation is discarded.
  - On the next edge every output takes its reset value.
  - No `out_valid` pulse appears for the discarded operation.
- Reset and `in_valid` in the same cycle: reset wins and nothing is accepted.

## Test plan
- Add, then sub: add `SrcA`=5, `SrcB`=7 → `ALUResult`=12, `Zero`=0, `out_valid` 1 cycle after accept. Then sub 3−5 → 0xFFFFFFFE. Then sub 9−9 → 0, `Zero`=1.
- sll and sra: sll 0x1, `SrcB`=4 → 0x10, with `out_valid` exactly 5 cycles after accept and `in_ready`=0 throughout. sra 0x80000000 by 31 → 0xFFFFFFFF after 32 cycles. srl of the same value by 31 → 0x1.
- Zero shift and compares: srl 0xDEADBEEF by `SrcB`=0x20 (shamt field 0) → 0xDEADBEEF after 1 cycle. slt −1 vs 1 → 1. sltu 0xFFFFFFFF vs 1 → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after an xor 0xF0F0 ^ 0x0FF0 → 0xFF00 held stable. A new `in_valid` during that time is not accepted. Raise `out_ready` → `in_ready`=1 the next cycle.
- Reset mid-shift: sll by 20, assert `reset` at cycle 8 → next cycle `out_valid`=0, `ALUResult`=0, `Zero`=1, `in_ready`=1. No result ever appears.
- Illegal code: `ALUControl`=1010 → `ALUResult`=0, `Zero`=1, `illegal`=1 after 1 cycle. The next legal op clears `illegal`.
